evp_horner_engine: RTL and testbench
====================================

Name: evp_horner_engine

Overview:
- Parametrised next-generation polynomial evaluation engine for the accelerator datapath.
- Evaluates p(x) = sum c_i*x^i over one of NUM_SETS stored coefficient sets using Horner's method: one multiply-add per coefficient, highest degree first.
- Reads the degree N from the N table, coefficients from the S table and x from the data buffer, all 1-cycle-latency synchronous RAMs outside the block.
- Adds range checking of N against MAX_DEG, unsigned overflow detection with saturation, and a synchronous abort via rst_instr.

Parameters:
- DATA_W, 16, width of x and coefficients.
- ACC_W, 32, width of accumulator and result.
- NUM_SETS, 8, number of coefficient sets; A selects one.
- MAX_DEG, 10, maximum legal degree; each set has MAX_DEG+1 slots.
- N_W, 5, width of N; all-ones means "set undefined".
- BUF_DEPTH, 1024, data buffer depth; BUF_AW = clog2(BUF_DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- rst_instr  in  1  synchronous abort to IDLE; highest priority after rst.
- start_evp  in  1  start request; sampled only in IDLE.
- A  in  clog2(NUM_SETS)  coefficient-set select; latched at start.
- rd_addr_data  in  BUF_AW  address of x; latched at start.
- N  in  N_W  N-table read data, valid the cycle after en_rd_N.
- x  in  DATA_W  data-buffer read data, valid the cycle after en_rd_data.
- c_i  in  DATA_W  S-table read data, valid the cycle after en_rd_S.
- en_rd_N  out  1  N-table read strobe.
- rd_addr_N  out  clog2(NUM_SETS)  N-table address.
- en_rd_data  out  1  data-buffer read strobe.
- rd_addr_data_out  out  BUF_AW  data-buffer read address.
- en_rd_S  out  1  S-table read strobe.
- rd_addr_S  out  clog2(NUM_SETS*(MAX_DEG+1))  equals A_l*(MAX_DEG+1)+idx.
- rd_addr_data_updated  out  BUF_AW  next unread data address.
- done_evp  out  1  one-cycle completion pulse.
- result  out  ACC_W  evaluated value.
- status  out  32  0 = OK, 1 = overflow, 2 = invalid N, all-ones = idle/never run.

Behaviour:
- Reset (rst low, or rst_instr high at a clock edge) clears all state, sets the state to IDLE and drives every output to 0, except status = 32'hFFFFFFFF.
- Read strobes are combinational from state and asserted one cycle only. Read addresses are driven from registers and are held stable.
- States and transitions:
  - IDLE: if start_evp, latch A_l and base_l, then go to RD_N.
  - RD_N: en_rd_N=1 with rd_addr_N=A_l; go to CHK_N.
  - CHK_N: latch N_l. If N is all-ones or N > MAX_DEG, go to ERROR; otherwise go to RD_X.
  - RD_X: en_rd_data=1 at base_l; en_rd_S=1 at idx=N_l; acc<=0; first<=1; go to MAC.
  - MAC: x_eff = first ? x : x_reg. If first, x_reg<=x. Compute acc <= acc*x_eff + c_i at 2*ACC_W width; first<=0. If idx==0 go to OUTPUT; otherwise idx<=idx-1 and go to FETCH.
  - FETCH: en_rd_S=1 at idx; go to MAC.
  - OUTPUT: result = ovf ? all-ones : acc; status = ovf ? 1 : 0; rd_addr_data_updated = base_l+1, wrapping modulo BUF_DEPTH.
  - ERROR: result=0, status=2; rd_addr_data_updated is unchanged.
  - DONE: done_evp=1; go to IDLE.
- Overflow: the sticky flag ovf is set if acc*x_eff or the following sum exceeds 2^ACC_W-1. It is cleared in RD_X. Once ovf is set, acc keeps its truncated value and is not used.
- Latency, counted from the clock edge that samples start_evp as cycle 0:
  - Valid N: done_evp is high in cycle 6+2N.
  - Invalid N: done_evp is high in cycle 4.
- result and status hold until the next OUTPUT or ERROR state, or until reset.
- start_evp outside IDLE is ignored. The A and rd_addr_data inputs may change freely after the start cycle.
- Back-to-back runs: start_evp high in the DONE cycle is ignored. It is accepted in the following IDLE cycle.
- Arithmetic is unsigned. x and c_i are zero-extended to ACC_W.

Decomposition:
- Package evp_pkg holds:
  - state encoding (4-bit localparams for IDLE, RD_N, CHK_N, RD_X, MAC, FETCH, OUTPUT, ERROR, DONE);
  - status codes ST_OK, ST_OVF, ST_BADN, ST_IDLE;
  - the clog2 function.
- One sub-module, evp_mac_sat: combinational acc*x+c with overflow flag, parametrised by ACC_W. The FSM, counters and registers stay in the top module.

Test Plan:
- Nominal: A=1, N=2, c0=3, c1=2, c2=1, x=4, base=100 -> result=27, status=0, done_evp in cycle 10, rd_addr_data_updated=101.
- Degree 0: N=0, c0=0xBEEF -> result=0x0000BEEF, status=0, done_evp in cycle 6, exactly one en_rd_S pulse.
- Invalid N: first N=31, then N=11 with MAX_DEG=10 -> result=0, status=2, done_evp in cycle 4, no en_rd_data or en_rd_S pulses.
- Overflow: N=3, all coefficients=0xFFFF, x=0xFFFF -> result=32'hFFFFFFFF, status=1.
- Abort: rst_instr pulsed during the second MAC -> IDLE next cycle, no done_evp, status=FFFFFFFF. A new start then runs the nominal case correctly.
- Address generation: A=7, N=10 -> rd_addr_S sequence 87,86,...,77. Base=1023 -> rd_addr_data_updated=0 (wrap).

Source files
------------

// File: rtl/evp_pkg.sv
// Shared definitions for the Horner polynomial evaluation engine:
// FSM state encoding, status codes and a constant-safe clog2.
package evp_pkg;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_RD_N   = 4'd1;
    localparam logic [3:0] S_CHK_N  = 4'd2;
    localparam logic [3:0] S_RD_X   = 4'd3;
    localparam logic [3:0] S_MAC    = 4'd4;
    localparam logic [3:0] S_FETCH  = 4'd5;
    localparam logic [3:0] S_OUTPUT = 4'd6;
    localparam logic [3:0] S_ERROR  = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    localparam logic [31:0] ST_OK   = 32'd0;
    localparam logic [31:0] ST_OVF  = 32'd1;
    localparam logic [31:0] ST_BADN = 32'd2;
    localparam logic [31:0] ST_IDLE = 32'hFFFF_FFFF;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int t = value - 1; t > 0; t = t >> 1) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/evp_mac_sat.sv
// Combinational Horner step y = acc*x + c with an unsigned overflow flag.
// The full double-width-plus-one sum is formed so both the product and the add are covered.
module evp_mac_sat #(
    parameter int ACC_W = 32
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] x,
    input  logic [ACC_W-1:0] c,
    output logic [ACC_W-1:0] y,
    output logic             ovf
);

    localparam int FW = 2 * ACC_W + 1;

    logic [FW-1:0] full;

    assign full = FW'(acc) * FW'(x) + FW'(c);
    assign y    = full[ACC_W-1:0];
    assign ovf  = |full[FW-1:ACC_W];

endmodule

// File: rtl/evp_horner_engine.sv
// Polynomial evaluation over a stored coefficient set using Horner's method,
// with degree range check, sticky overflow saturation and synchronous abort.
module evp_horner_engine
    import evp_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 32,
    parameter int NUM_SETS  = 8,
    parameter int MAX_DEG   = 10,
    parameter int N_W       = 5,
    parameter int BUF_DEPTH = 1024
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        rst_instr,
    input  logic                                        start_evp,
    input  logic [clog2(NUM_SETS)-1:0]                  A,
    input  logic [clog2(BUF_DEPTH)-1:0]                 rd_addr_data,
    input  logic [N_W-1:0]                              N,
    input  logic [DATA_W-1:0]                           x,
    input  logic [DATA_W-1:0]                           c_i,
    output logic                                        en_rd_N,
    output logic [clog2(NUM_SETS)-1:0]                  rd_addr_N,
    output logic                                        en_rd_data,
    output logic [clog2(BUF_DEPTH)-1:0]                 rd_addr_data_out,
    output logic                                        en_rd_S,
    output logic [clog2(NUM_SETS*(MAX_DEG+1))-1:0]      rd_addr_S,
    output logic [clog2(BUF_DEPTH)-1:0]                 rd_addr_data_updated,
    output logic                                        done_evp,
    output logic [ACC_W-1:0]                            result,
    output logic [31:0]                                 status
);

    localparam int A_W    = clog2(NUM_SETS);
    localparam int BUF_AW = clog2(BUF_DEPTH);
    localparam int S_AW   = clog2(NUM_SETS * (MAX_DEG + 1));

    logic [3:0]        state;
    logic [A_W-1:0]    a_l;
    logic [BUF_AW-1:0] base_l;
    logic [N_W-1:0]    idx;
    logic [S_AW-1:0]   addr_s;
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] x_reg;
    logic              first;
    logic              ovf;
    logic [ACC_W-1:0]  result_r;
    logic [31:0]       status_r;
    logic [BUF_AW-1:0] upd_r;

    logic [DATA_W-1:0] x_eff;
    logic [ACC_W-1:0]  mac_y;
    logic              mac_ovf;
    logic              n_bad;

    assign x_eff = first ? x : x_reg;
    assign n_bad = (N == '1) || (N > N_W'(MAX_DEG));

    evp_mac_sat #(.ACC_W(ACC_W)) u_mac (
        .acc (acc),
        .x   (ACC_W'(x_eff)),
        .c   (ACC_W'(c_i)),
        .y   (mac_y),
        .ovf (mac_ovf)
    );

    // Strobes decode straight from state so each lasts exactly one cycle.
    assign en_rd_N              = (state == S_RD_N);
    assign en_rd_data           = (state == S_RD_X);
    assign en_rd_S              = (state == S_RD_X) || (state == S_FETCH);
    assign done_evp             = (state == S_DONE);
    assign rd_addr_N            = a_l;
    assign rd_addr_data_out     = base_l;
    assign rd_addr_S            = addr_s;
    assign rd_addr_data_updated = upd_r;
    assign result               = result_r;
    assign status               = status_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            a_l      <= '0;
            base_l   <= '0;
            idx      <= '0;
            addr_s   <= '0;
            acc      <= '0;
            x_reg    <= '0;
            first    <= 1'b0;
            ovf      <= 1'b0;
            result_r <= '0;
            status_r <= ST_IDLE;
            upd_r    <= '0;
        end else if (rst_instr) begin
            state    <= S_IDLE;
            a_l      <= '0;
            base_l   <= '0;
            idx      <= '0;
            addr_s   <= '0;
            acc      <= '0;
            x_reg    <= '0;
            first    <= 1'b0;
            ovf      <= 1'b0;
            result_r <= '0;
            status_r <= ST_IDLE;
            upd_r    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_evp) begin
                        a_l    <= A;
                        base_l <= rd_addr_data;
                        state  <= S_RD_N;
                    end
                end
                S_RD_N: state <= S_CHK_N;
                S_CHK_N: begin
                    // idx doubles as the latched degree; it counts down to coefficient 0.
                    idx    <= N;
                    addr_s <= S_AW'(a_l) * S_AW'(MAX_DEG + 1) + S_AW'(N);
                    state  <= n_bad ? S_ERROR : S_RD_X;
                end
                S_RD_X: begin
                    acc   <= '0;
                    first <= 1'b1;
                    ovf   <= 1'b0;
                    state <= S_MAC;
                end
                S_MAC: begin
                    if (first) x_reg <= x;
                    acc   <= mac_y;
                    ovf   <= ovf | mac_ovf;
                    first <= 1'b0;
                    if (idx == '0) begin
                        state <= S_OUTPUT;
                    end else begin
                        idx    <= idx - 1'b1;
                        addr_s <= addr_s - 1'b1;
                        state  <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_MAC;
                S_OUTPUT: begin
                    result_r <= ovf ? '1 : acc;
                    status_r <= ovf ? ST_OVF : ST_OK;
                    upd_r    <= (base_l == BUF_AW'(BUF_DEPTH - 1)) ? '0 : base_l + 1'b1;
                    state    <= S_DONE;
                end
                S_ERROR: begin
                    result_r <= '0;
                    status_r <= ST_BADN;
                    state    <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_evp_horner_engine.sv
// Directed bench for evp_horner_engine with behavioural 1-cycle-latency N, S and data RAMs.
module tb_evp_horner_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_instr;
    logic        start_evp;
    logic [2:0]  A;
    logic [9:0]  rd_addr_data;
    logic [4:0]  N;
    logic [15:0] x;
    logic [15:0] c_i;
    logic        en_rd_N;
    logic [2:0]  rd_addr_N;
    logic        en_rd_data;
    logic [9:0]  rd_addr_data_out;
    logic        en_rd_S;
    logic [6:0]  rd_addr_S;
    logic [9:0]  rd_addr_data_updated;
    logic        done_evp;
    logic [31:0] result;
    logic [31:0] status;

    int checks = 0;
    int failures = 0;

    logic [4:0]  n_tab [8];
    logic [15:0] s_tab [88];
    logic [15:0] dbuf  [1024];

    int s_pulses = 0;
    int d_pulses = 0;
    int done_pulses = 0;
    logic [6:0] s_addr_q [$];

    always #5 clk = ~clk;

    evp_horner_engine dut (
        .clk                  (clk),
        .rst                  (rst),
        .rst_instr            (rst_instr),
        .start_evp            (start_evp),
        .A                    (A),
        .rd_addr_data         (rd_addr_data),
        .N                    (N),
        .x                    (x),
        .c_i                  (c_i),
        .en_rd_N              (en_rd_N),
        .rd_addr_N            (rd_addr_N),
        .en_rd_data           (en_rd_data),
        .rd_addr_data_out     (rd_addr_data_out),
        .en_rd_S              (en_rd_S),
        .rd_addr_S            (rd_addr_S),
        .rd_addr_data_updated (rd_addr_data_updated),
        .done_evp             (done_evp),
        .result               (result),
        .status               (status)
    );

    // Synchronous RAM models: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (en_rd_N)    N   <= n_tab[rd_addr_N];
        if (en_rd_data) x   <= dbuf[rd_addr_data_out];
        if (en_rd_S)    c_i <= s_tab[rd_addr_S];
    end

    always @(posedge clk) begin
        if (en_rd_S) begin
            s_pulses <= s_pulses + 1;
            s_addr_q.push_back(rd_addr_S);
        end
        if (en_rd_data) d_pulses <= d_pulses + 1;
        if (done_evp) done_pulses <= done_pulses + 1;
    end

    // Cycle 0 is the period in which start_evp is sampled; lat is the cycle with done_evp high.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            if (done_evp) begin
                lat = k + 1;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: no done_evp within 64 cycles");
        end
    endtask

    task automatic run_evp(input logic [2:0] a, input logic [9:0] base, input bit to_idle,
                           output int lat);
        @(negedge clk);
        A = a;
        rd_addr_data = base;
        start_evp = 1'b1;
        @(posedge clk);
        #1;
        start_evp = 1'b0;
        A = 3'($urandom_range(0, 7));
        rd_addr_data = 10'($urandom_range(0, 1023));
        wait_done(lat);
        if (to_idle) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rst_instr = 1'b0;
        start_evp = 1'b0;
        A = '0;
        rd_addr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (status !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL reset_status: got %h want ffffffff", status);
        end
        checks++;
        if ({result, done_evp, en_rd_N, en_rd_data, en_rd_S, rd_addr_S, rd_addr_data_updated} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: result=%h done=%b strobes=%b%b%b addr_s=%0d upd=%0d",
                     result, done_evp, en_rd_N, en_rd_data, en_rd_S, rd_addr_S, rd_addr_data_updated);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_nominal();
        int lat;
        run_evp(3'd1, 10'd100, 1'b1, lat);
        checks++;
        if (lat !== 10) begin failures++; $display("FAIL nominal_latency: got %0d want 10", lat); end
        checks++;
        if (result !== 32'd27) begin failures++; $display("FAIL nominal_result: got %0d want 27", result); end
        checks++;
        if (status !== 32'd0) begin failures++; $display("FAIL nominal_status: got %h want 0", status); end
        checks++;
        if (rd_addr_data_updated !== 10'd101) begin
            failures++;
            $display("FAIL nominal_upd: got %0d want 101", rd_addr_data_updated);
        end
    endtask

    task automatic test_invalid_n();
        int lat;
        int s0;
        int d0;
        logic [2:0] sets [2];
        sets[0] = 3'd3;
        sets[1] = 3'd4;
        for (int i = 0; i < 2; i++) begin
            s0 = s_pulses;
            d0 = d_pulses;
            run_evp(sets[i], 10'd500, 1'b1, lat);
            checks++;
            if (lat !== 4) begin failures++; $display("FAIL badn_latency[%0d]: got %0d want 4", i, lat); end
            checks++;
            if (result !== 32'd0 || status !== 32'd2) begin
                failures++;
                $display("FAIL badn_out[%0d]: result=%h status=%h want 0/2", i, result, status);
            end
            checks++;
            if (s_pulses != s0 || d_pulses != d0) begin
                failures++;
                $display("FAIL badn_reads[%0d]: S=%0d data=%0d pulses want 0/0", i, s_pulses - s0, d_pulses - d0);
            end
            checks++;
            if (rd_addr_data_updated !== 10'd101) begin
                failures++;
                $display("FAIL badn_upd[%0d]: got %0d want 101", i, rd_addr_data_updated);
            end
        end
    endtask

    task automatic test_degree0_back_to_back();
        int lat;
        int s0;
        s0 = s_pulses;
        run_evp(3'd2, 10'd200, 1'b0, lat);
        checks++;
        if (lat !== 6) begin failures++; $display("FAIL deg0_latency: got %0d want 6", lat); end
        checks++;
        if (result !== 32'h0000_BEEF || status !== 32'd0) begin
            failures++;
            $display("FAIL deg0_out: result=%h status=%h want 0000beef/0", result, status);
        end
        checks++;
        if (s_pulses - s0 != 1) begin failures++; $display("FAIL deg0_s_pulses: got %0d want 1", s_pulses - s0); end
        checks++;
        if (rd_addr_data_updated !== 10'd201) begin
            failures++;
            $display("FAIL deg0_upd: got %0d want 201", rd_addr_data_updated);
        end
        // Start raised during DONE must be ignored there and taken in the next IDLE cycle.
        @(negedge clk);
        A = 3'd1;
        rd_addr_data = 10'd100;
        start_evp = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (en_rd_N !== 1'b0) begin failures++; $display("FAIL b2b_done_ignore: en_rd_N=%b want 0", en_rd_N); end
        @(posedge clk);
        #1;
        start_evp = 1'b0;
        checks++;
        if (en_rd_N !== 1'b1) begin failures++; $display("FAIL b2b_accept: en_rd_N=%b want 1", en_rd_N); end
        wait_done(lat);
        checks++;
        if (lat !== 10 || result !== 32'd27) begin
            failures++;
            $display("FAIL b2b_run: lat=%0d result=%0d want 10/27", lat, result);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        int lat;
        run_evp(3'd5, 10'd300, 1'b1, lat);
        checks++;
        if (result !== 32'hFFFF_FFFF || status !== 32'd1) begin
            failures++;
            $display("FAIL ovf_out: result=%h status=%h want ffffffff/1", result, status);
        end
        checks++;
        if (lat !== 12) begin failures++; $display("FAIL ovf_latency: got %0d want 12", lat); end
    endtask

    task automatic test_abort();
        int lat;
        int s0;
        int dn0;
        s0 = s_pulses;
        @(negedge clk);
        A = 3'd1;
        rd_addr_data = 10'd100;
        start_evp = 1'b1;
        @(posedge clk);
        #1;
        start_evp = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (s_pulses - s0 != 2) begin failures++; $display("FAIL abort_pos: S pulses=%0d want 2", s_pulses - s0); end
        dn0 = done_pulses;
        @(negedge clk);
        rst_instr = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (status !== 32'hFFFF_FFFF || result !== 32'd0 || rd_addr_data_updated !== 10'd0) begin
            failures++;
            $display("FAIL abort_out: status=%h result=%h upd=%0d want ffffffff/0/0",
                     status, result, rd_addr_data_updated);
        end
        @(negedge clk);
        rst_instr = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (done_pulses != dn0 || en_rd_N !== 1'b0 || en_rd_S !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: done pulses=%0d en_rd_N=%b en_rd_S=%b want 0/0/0",
                     done_pulses - dn0, en_rd_N, en_rd_S);
        end
        run_evp(3'd1, 10'd100, 1'b1, lat);
        checks++;
        if (lat !== 10 || result !== 32'd27 || status !== 32'd0) begin
            failures++;
            $display("FAIL abort_rerun: lat=%0d result=%0d status=%h want 10/27/0", lat, result, status);
        end
    endtask

    task automatic test_addr_gen();
        int lat;
        int q0;
        int errs;
        logic [6:0] exp_addr;
        q0 = s_addr_q.size();
        run_evp(3'd7, 10'd1023, 1'b1, lat);
        checks++;
        if (s_addr_q.size() - q0 != 11) begin
            failures++;
            $display("FAIL addr_count: got %0d S reads want 11", s_addr_q.size() - q0);
        end else begin
            errs = 0;
            for (int i = 0; i < 11; i++) begin
                exp_addr = 7'(87 - i);
                if (s_addr_q[q0 + i] !== exp_addr) errs++;
            end
            if (errs != 0) begin
                failures++;
                $display("FAIL addr_seq: %0d of 11 addresses wrong, first got %0d want 87", errs, s_addr_q[q0]);
            end
        end
        checks++;
        if (rd_addr_data_updated !== 10'd0) begin
            failures++;
            $display("FAIL addr_wrap: got %0d want 0", rd_addr_data_updated);
        end
        checks++;
        if (result !== 32'd18434 || status !== 32'd0 || lat !== 26) begin
            failures++;
            $display("FAIL deg10: result=%0d status=%h lat=%0d want 18434/0/26", result, status, lat);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) n_tab[i] = 5'd0;
        for (int i = 0; i < 88; i++) s_tab[i] = 16'd0;
        for (int i = 0; i < 1024; i++) dbuf[i] = 16'd0;
        n_tab[1] = 5'd2;  s_tab[11] = 16'd3; s_tab[12] = 16'd2; s_tab[13] = 16'd1; dbuf[100] = 16'd4;
        n_tab[2] = 5'd0;  s_tab[22] = 16'hBEEF; dbuf[200] = 16'd9;
        n_tab[3] = 5'd31;
        n_tab[4] = 5'd11;
        n_tab[5] = 5'd3;  for (int i = 55; i <= 58; i++) s_tab[i] = 16'hFFFF; dbuf[300] = 16'hFFFF;
        n_tab[7] = 5'd10; for (int i = 0; i <= 10; i++) s_tab[77 + i] = 16'(i); dbuf[1023] = 16'd2;

        test_reset();
        test_nominal();
        test_invalid_n();
        test_degree0_back_to_back();
        test_overflow();
        test_abort();
        test_addr_gen();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
